// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART/ALU command sequencer:
// FSM state encoding, accepted ALU opcodes and error codes.
package uart_alu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_OP1  = 3'd1,
        RX_OP2  = 3'd2,
        EXEC    = 3'd3,
        TX_SEND = 3'd4,
        TX_WAIT = 3'd5
    } state_t;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] XOR = 6'b100110;
    localparam logic [5:0] SRA = 6'b000011;
    localparam logic [5:0] SRL = 6'b000010;
    localparam logic [5:0] NOR = 6'b100111;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_BAD_OP  = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    // A byte is a legal opcode only if it equals a zero-extended opcode, which
    // also forces every bit above the opcode field to zero.
    function automatic logic opcode_valid(input logic [7:0] b);
        return (b == {2'b00, ADD}) || (b == {2'b00, SUB}) ||
               (b == {2'b00, AND}) || (b == {2'b00, OR})  ||
               (b == {2'b00, XOR}) || (b == {2'b00, SRA}) ||
               (b == {2'b00, SRL}) || (b == {2'b00, NOR});
    endfunction

endpackage

// File: rtl/uart_alu_sequencer_if.sv
// Bus bundle between the sequencer and its UART receiver, UART transmitter
// and ALU neighbours; master is the sequencer side.
interface uart_alu_sequencer_if
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6,
    parameter int NB_OUT  = 16
) ();

    // RX: a byte is taken in the single cycle i_rx_done is high; there is no
    // back-pressure. TX: o_tx_start is raised only while i_tx_busy is low and
    // o_tx_data stays fixed until the matching i_tx_done pulse.
    logic [7:0]         i_rx_data;
    logic               i_rx_done;
    logic               i_tx_busy;
    logic               i_tx_done;
    logic [NB_OUT-1:0]  i_result;
    logic [NB_DATA-1:0] o_operand1;
    logic [NB_DATA-1:0] o_operand2;
    logic [NB_OP-1:0]   o_opcode;
    logic               o_tx_start;
    logic [7:0]         o_tx_data;
    logic               o_busy;
    logic               o_err;
    logic [1:0]         o_err_code;
    state_t             o_state;

    modport master (
        input  i_rx_data, i_rx_done, i_tx_busy, i_tx_done, i_result,
        output o_operand1, o_operand2, o_opcode, o_tx_start, o_tx_data,
        output o_busy, o_err, o_err_code, o_state
    );

    modport slave (
        output i_rx_data, i_rx_done, i_tx_busy, i_tx_done, i_result,
        input  o_operand1, o_operand2, o_opcode, o_tx_start, o_tx_data,
        input  o_busy, o_err, o_err_code, o_state
    );

endinterface

// File: rtl/uart_alu_timeout.sv
// Inter-byte watchdog: a down-counter reloaded on every received byte that
// flags expiry once it has run down to zero while enabled.
module uart_alu_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // Reload has priority so a byte arriving on the expiry cycle restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(TIMEOUT_CYCLES);
        end else if (run && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = run && (count == '0);

endmodule

// File: rtl/uart_alu_sequencer.sv
// Frame sequencer: collects opcode + two little-endian operands from the UART
// receiver, drives the ALU, and streams the result back LSB byte first.
module uart_alu_sequencer
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int NB_OUT         = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    uart_alu_sequencer_if.master bus
);

    localparam int OPB   = NB_DATA / 8;
    localparam int RSB   = NB_OUT / 8;
    localparam int MAXB  = (OPB > RSB) ? OPB : RSB;
    localparam int IDX_W = $clog2(MAXB + 1);

    localparam logic [IDX_W-1:0] OP_LAST  = IDX_W'(OPB - 1);
    localparam logic [IDX_W-1:0] RES_LAST = IDX_W'(RSB - 1);

    state_t             state;
    state_t             state_next;
    logic [NB_DATA-1:0] operand1_q;
    logic [NB_DATA-1:0] operand2_q;
    logic [NB_OP-1:0]   opcode_q;
    logic [NB_OUT-1:0]  result_q;
    logic [IDX_W-1:0]   idx;
    logic               err_q;
    logic [1:0]         err_code_q;

    logic       load_op;
    logic       wr_op1;
    logic       wr_op2;
    logic       cap_res;
    logic       idx_clr;
    logic       idx_inc;
    logic       tx_start;
    logic       err_set;
    logic [1:0] err_code_d;
    logic       in_rx;
    logic       expire;
    logic [7:0] tx_byte;

    assign in_rx = (state == RX_OP1) || (state == RX_OP2);

    uart_alu_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (i_clk),
        .rst    (i_reset),
        .load   (bus.i_rx_done),
        .run    (in_rx),
        .expire (expire)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_op    = 1'b0;
        wr_op1     = 1'b0;
        wr_op2     = 1'b0;
        cap_res    = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        tx_start   = 1'b0;
        err_set    = 1'b0;
        err_code_d = ERR_NONE;

        unique case (state)
            IDLE: begin
                if (bus.i_rx_done) begin
                    if (opcode_valid(bus.i_rx_data)) begin
                        load_op    = 1'b1;
                        idx_clr    = 1'b1;
                        state_next = RX_OP1;
                    end else begin
                        err_set    = 1'b1;
                        err_code_d = ERR_BAD_OP;
                    end
                end
            end
            RX_OP1: begin
                if (bus.i_rx_done) begin
                    wr_op1 = 1'b1;
                    if (idx == OP_LAST) begin
                        idx_clr    = 1'b1;
                        state_next = RX_OP2;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end else if (expire) begin
                    err_set    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_next = IDLE;
                end
            end
            RX_OP2: begin
                if (bus.i_rx_done) begin
                    wr_op2 = 1'b1;
                    if (idx == OP_LAST) begin
                        idx_clr    = 1'b1;
                        state_next = EXEC;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end else if (expire) begin
                    err_set    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_next = IDLE;
                end
            end
            EXEC: begin
                cap_res    = 1'b1;
                idx_clr    = 1'b1;
                state_next = TX_SEND;
            end
            TX_SEND: begin
                if (!bus.i_tx_busy) begin
                    tx_start   = 1'b1;
                    state_next = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (bus.i_tx_done) begin
                    if (idx == RES_LAST) begin
                        state_next = IDLE;
                    end else begin
                        idx_inc    = 1'b1;
                        state_next = TX_SEND;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Bytes arriving while the result is being computed or sent are lost.
        if (bus.i_rx_done && ((state == EXEC) || (state == TX_SEND) || (state == TX_WAIT))) begin
            err_set    = 1'b1;
            err_code_d = ERR_OVERRUN;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            operand1_q <= '0;
            operand2_q <= '0;
            opcode_q   <= '0;
            result_q   <= '0;
            idx        <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            if (load_op) begin
                opcode_q <= bus.i_rx_data[NB_OP-1:0];
            end
            if (wr_op1) begin
                operand1_q[8*idx +: 8] <= bus.i_rx_data;
            end
            if (wr_op2) begin
                operand2_q[8*idx +: 8] <= bus.i_rx_data;
            end
            if (cap_res) begin
                result_q <= bus.i_result;
            end
            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + 1'b1;
            end
            err_q <= err_set;
            if (err_set) begin
                err_code_q <= err_code_d;
            end
        end
    end

    // idx only advances on i_tx_done, so the selected byte is stable for the whole transfer.
    always_comb begin
        tx_byte = 8'h00;
        if ((state == TX_SEND) || (state == TX_WAIT)) begin
            for (int i = 0; i < RSB; i++) begin
                if (idx == IDX_W'(i)) begin
                    tx_byte = result_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.o_operand1 = operand1_q;
    assign bus.o_operand2 = operand2_q;
    assign bus.o_opcode   = opcode_q;
    assign bus.o_tx_start = tx_start;
    assign bus.o_tx_data  = tx_byte;
    assign bus.o_busy     = (state != IDLE);
    assign bus.o_err      = err_q;
    assign bus.o_err_code = err_code_q;
    assign bus.o_state    = state;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Randomised frame-level bench for uart_alu_sequencer with an ALU model,
// a transmitter model and a byte scoreboard.
module tb_uart_alu_sequencer;
    import uart_alu_pkg::*;

    localparam int NB_DATA = 16;
    localparam int NB_OP   = 6;
    localparam int NB_OUT  = 16;
    localparam int TIMEOUT = 40;
    localparam int OPB     = NB_DATA / 8;
    localparam int RSB     = NB_OUT / 8;
    localparam int TX_LEN  = 6;
    localparam int BOUND   = 3000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT ----------------
    logic [7:0] rx_data   = 8'h00;
    logic       rx_done   = 1'b0;
    logic       tx_busy_m = 1'b0;
    logic       hold_busy = 1'b0;
    logic       tx_done   = 1'b0;

    uart_alu_sequencer_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_OUT(NB_OUT)) bus ();

    uart_alu_sequencer #(
        .NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_OUT(NB_OUT), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // Reference ALU behaviour, used both as the ALU and as the expected-value model.
    function automatic logic [15:0] alu_ref(input logic [5:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        logic signed [15:0] sa;
        sa = a;
        case (op)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            6'b000011: return 16'(sa >>> b);
            6'b000010: return a >> b;
            6'b100111: return ~(a | b);
            default:   return 16'h0000;
        endcase
    endfunction

    assign bus.i_rx_data = rx_data;
    assign bus.i_rx_done = rx_done;
    assign bus.i_tx_busy = tx_busy_m | hold_busy;
    assign bus.i_tx_done = tx_done;
    assign bus.i_result  = alu_ref(bus.o_opcode, bus.o_operand1, bus.o_operand2);

    logic [7:0] valid_ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         start_cyc_q[$];
    int         n_checks  = 0;
    int         n_errs    = 0;
    int         done_cnt  = 0;
    int         hs_viol   = 0;
    int         hold_viol = 0;
    int         err_cnt   = 0;
    int         err_cyc   = 0;
    logic [1:0] last_code = 2'b00;
    int         last_rx_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- transmitter model ----------------
    initial begin : tx_model
        logic [7:0] held;
        forever begin
            @(negedge clk);
            if (bus.o_tx_start === 1'b1) begin
                obs_q.push_back(bus.o_tx_data);
                start_cyc_q.push_back(cyc);
                held = bus.o_tx_data;
                if (bus.i_tx_busy) hs_viol++;
                @(posedge clk); #1 tx_busy_m = 1'b1;
                repeat (TX_LEN) begin
                    @(negedge clk);
                    if (bus.o_tx_start) hs_viol++;
                    if (bus.o_busy && (bus.o_tx_data !== held)) hold_viol++;
                end
                @(posedge clk); #1 tx_busy_m = 1'b0; tx_done = 1'b1; done_cnt++;
                @(posedge clk); #1 tx_done = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus.o_err === 1'b1) begin
            err_cnt++;
            err_cyc   = cyc;
            last_code = bus.o_err_code;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_byte(input logic [7:0] b);
        @(posedge clk); #1 rx_data = b; rx_done = 1'b1; last_rx_cyc = cyc;
        @(posedge clk); #1 rx_done = 1'b0;
    endtask

    task automatic wait_obs(input int n);
        int t = 0;
        while (obs_q.size() < n && t < BOUND) begin @(negedge clk); t++; end
        check_eq("tx_byte_count", obs_q.size(), n);
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (done_cnt < n && t < BOUND) begin @(negedge clk); t++; end
        check_eq("tx_done_count", done_cnt, n);
    endtask

    task automatic finish_frame(input logic [15:0] r, input int base_err, input int base_done,
                                input bit overrun);
        exp_q.push_back(r[7:0]);
        exp_q.push_back(r[15:8]);
        wait_obs(RSB);
        wait_done(base_done + RSB);
        @(negedge clk);
        check_eq("busy_after_burst", bus.o_busy, 1'b0);
        for (int i = 0; i < RSB; i++) begin
            if (obs_q.size() > 0) check_eq("tx_byte", obs_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        check_eq("frame_err_count", err_cnt, overrun ? base_err + 1 : base_err);
        if (overrun) check_eq("overrun_code", last_code, ERR_OVERRUN);
    endtask

    task automatic run_frame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                             input bit gaps, input bit overrun, input bit busy_gate);
        int base_err  = err_cnt;
        int base_done = done_cnt;
        int n_last;
        int drop_cyc;
        obs_q.delete();
        start_cyc_q.delete();
        drive_byte(op);
        for (int i = 0; i < OPB; i++) begin
            if (gaps) repeat ($urandom_range(0, 4)) @(posedge clk);
            drive_byte(a[8*i +: 8]);
        end
        for (int i = 0; i < OPB; i++) begin
            if (gaps) repeat ($urandom_range(0, 4)) @(posedge clk);
            if (busy_gate && i == OPB - 1) hold_busy = 1'b1;
            drive_byte(b[8*i +: 8]);
        end
        n_last = last_rx_cyc;
        check_eq("opcode_reg", bus.o_opcode, op[5:0]);
        check_eq("operand1_reg", bus.o_operand1, a);
        check_eq("operand2_reg", bus.o_operand2, b);
        if (busy_gate) begin
            repeat (50) @(posedge clk);
            check_eq("start_gated_by_busy", obs_q.size(), 0);
            #1 hold_busy = 1'b0;
            drop_cyc = cyc;
            wait_obs(1);
            if (start_cyc_q.size() > 0) check_eq("start_after_busy_drop", start_cyc_q[0], drop_cyc);
        end else begin
            wait_obs(1);
            if (start_cyc_q.size() > 0) check_eq("first_start_latency", start_cyc_q[0] - n_last, 2);
        end
        if (overrun) drive_byte(8'h55);
        finish_frame(alu_ref(op[5:0], a, b), base_err, base_done, overrun);
        if (overrun) check_eq("opcode_after_overrun", bus.o_opcode, op[5:0]);
    endtask

    task automatic bad_opcode(input logic [7:0] b);
        int base_err = err_cnt;
        obs_q.delete();
        drive_byte(b);
        repeat (3) @(negedge clk);
        check_eq("bad_op_err_count", err_cnt, base_err + 1);
        check_eq("bad_op_code", last_code, ERR_BAD_OP);
        check_eq("bad_op_no_tx", obs_q.size(), 0);
        check_eq("bad_op_idle", bus.o_state, IDLE);
    endtask

    function automatic bit is_valid(input logic [7:0] b);
        foreach (valid_ops[i]) if (valid_ops[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] b;
        int         base_err;
        int         base_done;
        int         n_last;
        int         t;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_tx_start", bus.o_tx_start, 1'b0);
        check_eq("rst_tx_data", bus.o_tx_data, 8'h00);
        check_eq("rst_busy", bus.o_busy, 1'b0);
        check_eq("rst_err", bus.o_err, 1'b0);
        check_eq("rst_err_code", bus.o_err_code, 2'b00);
        check_eq("rst_operand1", bus.o_operand1, 16'h0000);
        check_eq("rst_opcode", bus.o_opcode, 6'h00);
        check_eq("rst_state", bus.o_state, IDLE);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // ADD frame from the reference scenario: 0x1234 + 0x0101.
        run_frame(8'h20, 16'h1234, 16'h0101, 1'b0, 1'b0, 1'b0);

        // Rejected opcodes, then a normal frame.
        bad_opcode(8'h3F);
        bad_opcode(8'hA0);
        for (int k = 0; k < 4; k++) begin
            do b = 8'($urandom_range(0, 255)); while (is_valid(b));
            bad_opcode(b);
        end
        run_frame(8'h22, 16'h00F0, 16'h0011, 1'b1, 1'b0, 1'b0);

        // Silence after the first operand byte ends the frame exactly at expiry.
        base_err = err_cnt;
        obs_q.delete();
        drive_byte(8'h20);
        drive_byte(8'h34);
        n_last = last_rx_cyc;
        t = 0;
        while (err_cnt == base_err && t < TIMEOUT + 20) begin @(negedge clk); t++; end
        check_eq("timeout_err_count", err_cnt, base_err + 1);
        check_eq("timeout_cycle", err_cyc - n_last, TIMEOUT + 2);
        check_eq("timeout_code", last_code, ERR_TIMEOUT);
        @(negedge clk);
        check_eq("timeout_idle", bus.o_busy, 1'b0);
        check_eq("timeout_no_tx", obs_q.size(), 0);
        check_eq("timeout_partial_op1", bus.o_operand1[7:0], 8'h34);

        // A byte landing on the expiry cycle keeps the frame alive.
        base_err  = err_cnt;
        base_done = done_cnt;
        obs_q.delete();
        drive_byte(8'h20);
        drive_byte(8'h34);
        repeat (TIMEOUT - 1) @(posedge clk);
        drive_byte(8'h12);
        drive_byte(8'h01);
        drive_byte(8'h01);
        finish_frame(alu_ref(6'h20, 16'h1234, 16'h0101), base_err, base_done, 1'b0);

        // Overrun while the first result byte is on the wire.
        run_frame(8'h26, 16'hA5C3, 16'h0FF0, 1'b0, 1'b1, 1'b0);
        check_eq("overrun_idle", bus.o_state, IDLE);

        // Transmitter busy for 50 cycles after EXEC.
        run_frame(8'h24, 16'hBEEF, 16'h0F0F, 1'b0, 1'b0, 1'b1);

        // Reset between the two result bytes.
        base_done = done_cnt;
        obs_q.delete();
        start_cyc_q.delete();
        drive_byte(8'h25);
        drive_byte(8'h11); drive_byte(8'h22);
        drive_byte(8'h33); drive_byte(8'h44);
        t = 0;
        while (done_cnt < base_done + 1 && t < BOUND) begin @(posedge clk); #2; t++; end
        check_eq("reset_first_done", done_cnt, base_done + 1);
        rst = 1'b1;
        #1;
        check_eq("midrst_tx_start", bus.o_tx_start, 1'b0);
        check_eq("midrst_tx_data", bus.o_tx_data, 8'h00);
        check_eq("midrst_busy", bus.o_busy, 1'b0);
        check_eq("midrst_err_code", bus.o_err_code, 2'b00);
        check_eq("midrst_operand2", bus.o_operand2, 16'h0000);
        check_eq("midrst_opcode", bus.o_opcode, 6'h00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (TX_LEN + 4) @(posedge clk);
        check_eq("midrst_single_byte", obs_q.size(), 1);
        run_frame(8'h27, 16'h1357, 16'h2468, 1'b0, 1'b0, 1'b0);

        // Randomised frames.
        for (int k = 0; k < 24; k++) begin
            run_frame(valid_ops[$urandom_range(0, 7)], 16'($urandom), 16'($urandom),
                      1'b1, 1'b0, 1'b0);
            repeat ($urandom_range(0, 6)) @(posedge clk);
        end

        check_eq("tx_start_while_busy", hs_viol, 0);
        check_eq("tx_data_hold", hold_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
